// File: rtl/mem_cache_ctrl.sv
// Memory-stage data cache: direct-mapped, write-through, no-write-allocate, SRAM backed.
// Optional hit/miss counters when MEM_CACHE_STATS_EN is defined.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | accept a load/store; a read hit is served with no stall
// S_RD_MISS | SRAM read outstanding; the line is refilled on sram_ready
// S_WR_THRU | SRAM write outstanding; the pipeline is released on sram_ready
module mem_cache_ctrl #(
    parameter int DEPTH     = 64,
    parameter int BASE_ADDR = 1024,
    parameter int TAG_W     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] ALU_Res,
    input  logic [31:0] Val_Rm,
    output logic [31:0] mem_rdata,
    output logic        freeze,
    output logic        sram_req,
    output logic        sram_we,
    output logic [29:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata,
    input  logic        sram_ready
`ifdef MEM_CACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int          IDX_W = $clog2(DEPTH);
    localparam logic [31:0] BASE  = 32'(BASE_ADDR);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_MISS = 2'd1,
        S_WR_THRU = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [DEPTH-1:0] r_valid;
    logic [TAG_W-1:0] r_tag_mem  [DEPTH];
    logic [31:0]      r_data_mem [DEPTH];

    logic        r_sram_req;
    logic        r_sram_we;
    logic [29:0] r_sram_addr;
    logic [31:0] r_sram_wdata;
    logic [31:0] r_rdata;

    logic [31:0]      w_ea;
    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic [IDX_W-1:0] w_lat_idx;
    logic [TAG_W-1:0] w_lat_tag;
    logic             w_unused_ea_lo;
    logic             w_hit;
    logic             w_rd;
    logic             w_wr;

    logic        w_freeze;
    logic [31:0] w_rdata;
    logic        w_issue_rd;
    logic        w_issue_wr;
    logic        w_fill;
    logic        w_done;
    logic        w_hit_rd;

    assign w_ea           = ALU_Res - BASE;
    assign w_idx          = w_ea[IDX_W+1:2];
    assign w_tag          = w_ea[TAG_W+IDX_W+1:IDX_W+2];
    assign w_unused_ea_lo = ^w_ea[1:0];

    // Refill targets the line of the latched miss address, not the live inputs.
    assign w_lat_idx = r_sram_addr[IDX_W-1:0];
    assign w_lat_tag = r_sram_addr[TAG_W+IDX_W-1:IDX_W];

    assign w_hit = r_valid[w_idx] && (r_tag_mem[w_idx] == w_tag);
    assign w_wr  = MEM_W_EN;
    assign w_rd  = MEM_R_EN && !MEM_W_EN;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_freeze   = 1'b0;
        w_rdata    = r_rdata;
        w_issue_rd = 1'b0;
        w_issue_wr = 1'b0;
        w_fill     = 1'b0;
        w_done     = 1'b0;
        w_hit_rd   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_wr) begin
                    w_freeze   = 1'b1;
                    w_issue_wr = 1'b1;
                    w_next     = S_WR_THRU;
                end else if (w_rd) begin
                    if (w_hit) begin
                        w_rdata  = r_data_mem[w_idx];
                        w_hit_rd = 1'b1;
                    end else begin
                        w_freeze   = 1'b1;
                        w_issue_rd = 1'b1;
                        w_next     = S_RD_MISS;
                    end
                end
            end
            S_RD_MISS: begin
                if (sram_ready) begin
                    w_rdata = sram_rdata;
                    w_fill  = 1'b1;
                    w_done  = 1'b1;
                    w_next  = S_IDLE;
                end else begin
                    w_freeze = 1'b1;
                end
            end
            S_WR_THRU: begin
                if (sram_ready) begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end else begin
                    w_freeze = 1'b1;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid      <= '0;
            r_sram_req   <= 1'b0;
            r_sram_we    <= 1'b0;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
            r_rdata      <= '0;
        end else begin
            r_rdata <= w_rdata;
            if (w_issue_rd) begin
                r_sram_req  <= 1'b1;
                r_sram_we   <= 1'b0;
                r_sram_addr <= w_ea[31:2];
            end else if (w_issue_wr) begin
                r_sram_req   <= 1'b1;
                r_sram_we    <= 1'b1;
                r_sram_addr  <= w_ea[31:2];
                r_sram_wdata <= Val_Rm;
            end else if (w_done) begin
                r_sram_req <= 1'b0;
            end
            if (w_fill) begin
                r_valid[w_lat_idx] <= 1'b1;
            end
        end
    end

    // Tag/data arrays need no reset: the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_data_mem[w_lat_idx] <= sram_rdata;
            r_tag_mem[w_lat_idx]  <= w_lat_tag;
        end else if (w_issue_wr && w_hit) begin
            r_data_mem[w_idx] <= Val_Rm;
        end
    end

`ifdef MEM_CACHE_STATS_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_hit_rd && (r_hit_cnt != 32'hFFFF_FFFF)) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
            if (w_issue_rd && (r_miss_cnt != 32'hFFFF_FFFF)) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif

    // Reset must drop freeze immediately even while a request is held on the inputs.
    assign freeze     = rst && w_freeze;
    assign mem_rdata  = w_rdata;
    assign sram_req   = r_sram_req;
    assign sram_we    = r_sram_we;
    assign sram_addr  = r_sram_addr;
    assign sram_wdata = r_sram_wdata;

endmodule

// File: tb/tb_mem_cache_ctrl.sv
// Scoreboard bench for mem_cache_ctrl: directed loads/stores against a latency-programmable SRAM model.
// Define MEM_CACHE_STATS_EN to also exercise the hit/miss counters.
module tb_mem_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] ALU_Res;
    logic [31:0] Val_Rm;
    logic [31:0] mem_rdata;
    logic        freeze;
    logic        sram_req;
    logic        sram_we;
    logic [29:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        sram_ready;
`ifdef MEM_CACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    mem_cache_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .MEM_R_EN   (MEM_R_EN),
        .MEM_W_EN   (MEM_W_EN),
        .ALU_Res    (ALU_Res),
        .Val_Rm     (Val_Rm),
        .mem_rdata  (mem_rdata),
        .freeze     (freeze),
        .sram_req   (sram_req),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .sram_ready (sram_ready)
`ifdef MEM_CACHE_STATS_EN
        ,
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_wr;
        logic [31:0] data;
        int          stalls;
    } acc_t;

    typedef struct {
        logic        we;
        logic [29:0] addr;
        logic [31:0] wdata;
    } sram_t;

    acc_t  exp_q[$];
    sram_t sram_q[$];

    int          n_vec = 0;
    int          n_err = 0;
    int          lat = 3;
    bit          mon_en = 1'b0;
    logic [31:0] mem_m [0:1023];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // SRAM: ready pulses after req has been high for `lat` full cycles.
    initial begin
        int cnt;
        cnt = 0;
        sram_ready = 1'b0;
        sram_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (sram_req && !sram_ready) begin
                if (cnt >= lat) begin
                    sram_ready = 1'b1;
                    if (sram_we) mem_m[sram_addr[9:0]] = sram_wdata;
                    else         sram_rdata = mem_m[sram_addr[9:0]];
                end else begin
                    cnt++;
                end
            end else begin
                sram_ready = 1'b0;
                cnt = 0;
            end
        end
    end

    // Monitor: checks SRAM traffic each cycle and every completed access.
    initial begin
        int    stall;
        acc_t  e;
        sram_t s;
        stall = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                stall = 0;
            end else begin
                if (sram_req) begin
                    if (sram_q.size() == 0) begin
                        check("sram_req_unexpected", {31'b0, sram_req}, 32'h0);
                    end else begin
                        s = sram_q[0];
                        check("sram_we", {31'b0, sram_we}, {31'b0, s.we});
                        check("sram_addr", {2'b0, sram_addr}, {2'b0, s.addr});
                        if (s.we) check("sram_wdata", sram_wdata, s.wdata);
                        if (sram_ready) void'(sram_q.pop_front());
                    end
                end
                if (MEM_R_EN || MEM_W_EN) begin
                    if (freeze) begin
                        stall++;
                    end else if (exp_q.size() == 0) begin
                        check("completion_unexpected", {31'b0, freeze}, 32'h1);
                    end else begin
                        e = exp_q.pop_front();
                        check("stall_cycles", stall, e.stalls);
                        if (!e.is_wr) check("mem_rdata", mem_rdata, e.data);
                        stall = 0;
                    end
                end
            end
        end
    end

    // Issue one access at posedge+1 and hold it until the pipeline advances.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input int stalls, input logic [31:0] exp_data,
                          input logic has_sram, input logic [29:0] exp_saddr);
        acc_t  e;
        sram_t s;
        bit    done;
        e.is_wr  = wr;
        e.data   = exp_data;
        e.stalls = stalls;
        exp_q.push_back(e);
        if (has_sram) begin
            s.we    = wr;
            s.addr  = exp_saddr;
            s.wdata = wdata;
            sram_q.push_back(s);
        end
        MEM_R_EN = rd;
        MEM_W_EN = wr;
        ALU_Res  = addr;
        Val_Rm   = wdata;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (!freeze) done = 1'b1;
        end
        if (!done) check("access_timeout", {31'b0, freeze}, 32'h0);
        @(posedge clk);
        #1;
        MEM_R_EN = 1'b0;
        MEM_W_EN = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem_m[i] = '0;
        mem_m[0]   = 32'hDEADBEEF;
        mem_m[1]   = 32'h11112222;
        mem_m[64]  = 32'hCAFEF00D;
        mem_m[256] = 32'h0BADC0DE;

        rst      = 1'b0;
        MEM_R_EN = 1'b1;
        MEM_W_EN = 1'b0;
        ALU_Res  = 32'd1024;
        Val_Rm   = 32'h0;
        #22;
        check("rst_freeze", {31'b0, freeze}, 32'h0);
        check("rst_sram_req", {31'b0, sram_req}, 32'h0);
        check("rst_sram_we", {31'b0, sram_we}, 32'h0);
        check("rst_sram_addr", {2'b0, sram_addr}, 32'h0);
        check("rst_sram_wdata", sram_wdata, 32'h0);
        check("rst_mem_rdata", mem_rdata, 32'h0);
`ifdef MEM_CACHE_STATS_EN
        check("rst_hit_cnt", hit_cnt, 32'h0);
        check("rst_miss_cnt", miss_cnt, 32'h0);
`endif
        MEM_R_EN = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        access(1, 0, 32'd1024, 32'h0,         4, 32'hDEADBEEF, 1, 30'd0);
        access(1, 0, 32'd1024, 32'h0,         0, 32'hDEADBEEF, 0, 30'd0);
        access(0, 1, 32'd1024, 32'h12345678,  4, 32'h0,        1, 30'd0);
        access(1, 0, 32'd1024, 32'h0,         0, 32'h12345678, 0, 30'd0);
        access(1, 0, 32'd1280, 32'h0,         4, 32'hCAFEF00D, 1, 30'd64);
        access(1, 0, 32'd1024, 32'h0,         4, 32'h12345678, 1, 30'd0);
        access(0, 1, 32'd2048, 32'h55AA55AA,  4, 32'h0,        1, 30'd256);
        access(1, 0, 32'd2048, 32'h0,         4, 32'h55AA55AA, 1, 30'd256);
        lat = 1;
        access(1, 1, 32'd1280, 32'hA5A5A5A5,  2, 32'h0,        1, 30'd64);
        lat = 0;
        access(1, 0, 32'd1028, 32'h0,         1, 32'h11112222, 1, 30'd1);
        access(1, 0, 32'd2048, 32'h0,         0, 32'h55AA55AA, 0, 30'd0);

        // Abort a refill with reset while SRAM is still busy.
        mon_en   = 1'b0;
        lat      = 10;
        MEM_R_EN = 1'b1;
        ALU_Res  = 32'd1280;
        repeat (3) @(posedge clk);
        #1;
        check("pre_abort_sram_req", {31'b0, sram_req}, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check("abort_sram_req", {31'b0, sram_req}, 32'h0);
        check("abort_freeze", {31'b0, freeze}, 32'h0);
        check("abort_mem_rdata", mem_rdata, 32'h0);
`ifdef MEM_CACHE_STATS_EN
        check("abort_hit_cnt", hit_cnt, 32'h0);
        check("abort_miss_cnt", miss_cnt, 32'h0);
`endif
        MEM_R_EN = 1'b0;
        exp_q.delete();
        sram_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        lat    = 3;
        mon_en = 1'b1;

        access(1, 0, 32'd1024, 32'h0, 4, 32'h12345678, 1, 30'd0);
        access(1, 0, 32'd1280, 32'h0, 4, 32'hA5A5A5A5, 1, 30'd64);
        access(1, 0, 32'd1280, 32'h0, 0, 32'hA5A5A5A5, 0, 30'd0);
`ifdef MEM_CACHE_STATS_EN
        check("hit_cnt", hit_cnt, 32'd1);
        check("miss_cnt", miss_cnt, 32'd2);
`endif

        repeat (3) @(posedge clk);
        check("exp_q_drained", exp_q.size(), 32'd0);
        check("sram_q_drained", sram_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
